fb_scanout_arbiter: RTL

FB_SCANOUT_ARBITER -- requirements
Module: fb_scanout_arbiter

---
 rtl/fb_scanout_arbiter_pkg.sv | 33 +++
 rtl/fb_scanout_arbiter_if.sv | 26 ++
 rtl/fb_prio_arb.sv | 26 ++
 rtl/fb_scanout_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fb_scanout_arbiter_pkg.sv
// Shared video definitions: scanout FSM encoding, 1024x768 geometry, RGB565 layout
// and the small helpers used by the framebuffer scanout arbiter.
package video_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_VID_CMD  = 2'd1;
  localparam logic [1:0] ST_VID_DATA = 2'd2;
  localparam logic [1:0] ST_WR_CMD   = 2'd3;

  localparam int H_ACTIVE     = 1024;
  localparam int V_ACTIVE     = 768;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int PIXEL_W = RGB_R_W + RGB_G_W + RGB_B_W;

  localparam int LEN_W = 5;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_VID  = 2'd1,
    GRANT_WR   = 2'd2
  } grant_e;

  // Burst length for the next video read: a full burst, or the frame's tail.
  function automatic logic [LEN_W-1:0] clip_len(input logic [31:0] remain,
                                                input logic [31:0] burst);
    clip_len = (remain < burst) ? remain[LEN_W-1:0] : burst[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/fb_scanout_arbiter_if.sv
// Memory command / read-return bus between the scanout arbiter and the memory controller.
interface fb_scanout_arbiter_if #(
  parameter int ADDR_W = 22
);
  import video_pkg::*;

  logic                mem_cmd_valid;
  logic                mem_cmd_ready;
  logic                mem_cmd_we;
  logic [ADDR_W-1:0]   mem_cmd_addr;
  logic [LEN_W-1:0]    mem_cmd_len;
  logic [PIXEL_W-1:0]  mem_wdata;
  logic [PIXEL_W-1:0]  mem_rdata;
  logic                mem_rvalid;

  modport master (
    output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_len, mem_wdata,
    input  mem_cmd_ready, mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_len, mem_wdata,
    output mem_cmd_ready, mem_rdata, mem_rvalid
  );

endinterface

// File: rtl/fb_prio_arb.sv
// Purely combinational grant decision for the scanout arbiter:
// urgent video first, then the pixel writer, then non-urgent video.
module fb_prio_arb
  import video_pkg::*;
(
  input  logic   i_idle,
  input  logic   i_vid_need,
  input  logic   i_vid_urgent,
  input  logic   i_wr_req,
  output grant_e o_grant
);

  always_comb begin
    o_grant = GRANT_NONE;
    if (i_idle) begin
      if (i_vid_urgent) begin
        o_grant = GRANT_VID;
      end else if (i_wr_req) begin
        o_grant = GRANT_WR;
      end else if (i_vid_need) begin
        o_grant = GRANT_VID;
      end
    end
  end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Framebuffer scanout arbiter: shares one memory port between burst reads that
// refill the scanout FIFO and single-word pixel writes.
module fb_scanout_arbiter
  import video_pkg::*;
#(
  parameter int unsigned FB_BASE     = 0,
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FRAME_WORDS = 786432,
  parameter int unsigned FIFO_DEPTH  = 1024,
  parameter int unsigned FIFO_LOW    = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_start,
  input  logic [10:0]          fifo_level,
  output logic                 fifo_wr,
  output logic [15:0]          fifo_wdata,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [15:0]          wr_data,
  output logic                 wr_ack,
  fb_scanout_arbiter_if.master mem,
  output logic                 underrun
);

  localparam int                REM_W      = $clog2(FRAME_WORDS + 1);
  localparam logic [11:0]       NEED_LIMIT = 12'(FIFO_DEPTH - BURST_LEN);
  localparam logic [10:0]       LOW_MARK   = 11'(FIFO_LOW);
  localparam logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(FB_BASE);
  localparam logic [REM_W-1:0]  FRAME_REM  = REM_W'(FRAME_WORDS);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [REM_W-1:0]  r_remain;
  logic [LEN_W-1:0]  r_outstanding;
  logic [LEN_W-1:0]  r_beats;
  logic              r_frame_pend;
  logic              r_underrun;
  logic              r_cmd_we;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [LEN_W-1:0]  r_cmd_len;
  logic [15:0]       r_cmd_wdata;

  logic              w_vid_need;
  logic              w_vid_urgent;
  logic [LEN_W-1:0]  w_vid_len;
  logic              w_cmd_hs;
  logic              w_beat;
  logic              w_last_beat;
  logic              w_frame_load;
  logic              w_idle;
  grant_e            w_grant;

  assign w_vid_need   = (r_remain != '0) &&
                        (({1'b0, fifo_level} + 12'(r_outstanding)) <= NEED_LIMIT);
  assign w_vid_urgent = w_vid_need && (fifo_level < LOW_MARK);
  assign w_vid_len    = clip_len(32'(r_remain), 32'(BURST_LEN));
  assign w_cmd_hs     = mem.mem_cmd_valid && mem.mem_cmd_ready;
  assign w_beat       = (r_state == ST_VID_DATA) && mem.mem_rvalid;
  assign w_last_beat  = w_beat && (r_beats == LEN_W'(1));

  // A frame restart requested during a read burst is deferred to its last beat.
  assign w_frame_load = (((r_state == ST_IDLE) || (r_state == ST_WR_CMD)) && frame_start) ||
                        (w_last_beat && (frame_start || r_frame_pend));

  // The cycle that reloads the frame pointers issues no grant, so a video burst
  // never mixes the old frame's address with the new frame's countdown.
  assign w_idle = (r_state == ST_IDLE) && !frame_start;

  fb_prio_arb u_prio_arb (
    .i_idle       (w_idle),
    .i_vid_need   (w_vid_need),
    .i_vid_urgent (w_vid_urgent),
    .i_wr_req     (wr_req),
    .o_grant      (w_grant)
  );

  assign mem.mem_cmd_valid = (r_state == ST_VID_CMD) || (r_state == ST_WR_CMD);
  assign mem.mem_cmd_we    = r_cmd_we;
  assign mem.mem_cmd_addr  = r_cmd_addr;
  assign mem.mem_cmd_len   = r_cmd_len;
  assign mem.mem_wdata     = r_cmd_wdata;

  assign fifo_wr    = w_beat;
  assign fifo_wdata = mem.mem_rdata;
  assign wr_ack     = (r_state == ST_WR_CMD) && mem.mem_cmd_ready;
  assign underrun   = r_underrun;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_rd_ptr      <= BASE_ADDR;
      r_remain      <= '0;
      r_outstanding <= '0;
      r_beats       <= '0;
      r_cmd_we      <= 1'b0;
      r_cmd_addr    <= '0;
      r_cmd_len     <= '0;
      r_cmd_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant == GRANT_VID) begin
            r_state       <= ST_VID_CMD;
            r_cmd_we      <= 1'b0;
            r_cmd_addr    <= r_rd_ptr;
            r_cmd_len     <= w_vid_len;
            r_outstanding <= r_outstanding + w_vid_len;
          end else if (w_grant == GRANT_WR) begin
            r_state     <= ST_WR_CMD;
            r_cmd_we    <= 1'b1;
            r_cmd_addr  <= wr_addr;
            r_cmd_len   <= LEN_W'(1);
            r_cmd_wdata <= wr_data;
          end
        end
        ST_VID_CMD: begin
          if (w_cmd_hs) begin
            r_state  <= ST_VID_DATA;
            r_rd_ptr <= r_rd_ptr + ADDR_W'(r_cmd_len);
            r_remain <= r_remain - REM_W'(r_cmd_len);
            r_beats  <= r_cmd_len;
          end
        end
        ST_VID_DATA: begin
          if (w_beat) begin
            r_beats       <= r_beats - LEN_W'(1);
            r_outstanding <= r_outstanding - LEN_W'(1);
            if (w_last_beat) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_WR_CMD: begin
          if (w_cmd_hs) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_frame_load) begin
        r_rd_ptr <= BASE_ADDR;
        r_remain <= FRAME_REM;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_pend <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (w_frame_load) begin
        r_frame_pend <= 1'b0;
      end else if (frame_start && ((r_state == ST_VID_CMD) || (r_state == ST_VID_DATA))) begin
        r_frame_pend <= 1'b1;
      end

      if (w_frame_load) begin
        r_underrun <= 1'b0;
      end else if ((fifo_level == 11'd0) && (r_remain != '0) && !w_beat) begin
        r_underrun <= 1'b1;
      end
    end
  end

endmodule
